// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port whole-line arbiter in front of a single memory/L2 port.
// It keeps exactly one downstream transaction in flight. The winner's op,
// address and write line are captured at grant, so the downstream side sees
// stable values for the whole transaction. The selection policy is either
// fixed priority (lowest index wins) or round-robin from a rotating pointer.
module mem_arbiter_n #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int RR_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LINE_W-1:0]   req_wdata,
  output logic [LINE_W-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]          req_resp,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_resp,
  output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
  output logic                        busy
);

  localparam int GNT_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [GNT_W-1:0]   grant_q, grant_d;
  logic               op_write_q, op_write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] active;
  logic [GNT_W-1:0]   winner;
  logic               found;

  // Pick the winning port: scan from 0 (fixed) or from the pointer (round-robin).
  always_comb begin : pick_winner
    int idx;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    active = req_read | req_write;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (RR_MODE != 0) ? (int'(rr_ptr_q) + k) % NUM_REQ : k;
      if (!found && active[idx]) begin
        found  = 1'b1;
        winner = idx[GNT_W-1:0];
      end
    end
  end

  // Next-state logic: latch the winner in IDLE, wait for mem_resp, then one DONE cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d    = winner;
          // A port raising read and write together is serviced as a write.
          op_write_d = req_write[winner];
          addr_d     = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          wdata_d    = req_wdata[int'(winner)*LINE_W +: LINE_W];
          if (RR_MODE != 0) begin
            rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          end
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_resp) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: strobes only in ISSUE; resp and read data pass straight through on mem_resp.
  always_comb begin
    mem_read  = (state_q == S_ISSUE) && !op_write_q;
    mem_write = (state_q == S_ISSUE) && op_write_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    grant_idx = grant_q;
    busy      = (state_q != S_IDLE);
    req_resp  = '0;
    req_rdata = '0;
    if ((state_q == S_ISSUE) && mem_resp) begin
      req_resp[grant_q] = 1'b1;
      req_rdata         = mem_rdata;
    end
  end

  // State and captured-transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      op_write_q <= 1'b0;
      // NOTE: the wide addr/wdata registers are reset too, because mem_addr/mem_wdata must read zero out of reset.
      addr_q     <= '0;
      wdata_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
      state_q    <= state_d;
      grant_q    <= grant_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Testbench for mem_arbiter_n. Instance u_a is two-port fixed priority and
// instance u_b is four-port round-robin. Each one has a small line memory
// model. The stimulus pushes the expected completions into per-instance
// queues. A monitor pops those queues and compares them whenever req_resp
// fires.
module tb_mem_arbiter_n;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [255:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  // Instance A: NUM_REQ=2, fixed priority.
  logic [1:0]    a_req_read, a_req_write, a_req_resp;
  logic [63:0]   a_req_addr;
  logic [511:0]  a_req_wdata;
  logic [255:0]  a_req_rdata;
  logic [0:0]    a_grant;
  logic          a_busy;

  // Instance B: NUM_REQ=4, round-robin.
  logic [3:0]    b_req_read, b_req_write, b_req_resp;
  logic [127:0]  b_req_addr;
  logic [1023:0] b_req_wdata;
  logic [255:0]  b_req_rdata;
  logic [1:0]    b_grant;
  logic          b_busy;

  // Downstream sides, index 0 = A, 1 = B.
  logic [1:0]    m_read, m_write, m_resp, inject;
  logic [31:0]   m_addr [2];
  logic [255:0]  m_wdata [2];
  logic [255:0]  m_rdata [2];
  int            mem_wait [2];

  exp_t q_a[$];
  exp_t q_b[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_proto = 0;

  int a_rd_cyc, a_wr_cyc, b_rd_cyc, b_wr_cyc, tick_no, resp_at;
  logic [1:0] seen_a;
  logic [3:0] seen_b;

  initial forever #5 clk = ~clk;

  mem_arbiter_n #(.NUM_REQ(2), .ADDR_W(32), .LINE_W(256), .RR_MODE(0)) u_a (
    .clk(clk), .rst(rst),
    .req_read(a_req_read), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_rdata(a_req_rdata), .req_resp(a_req_resp),
    .mem_read(m_read[0]), .mem_write(m_write[0]),
    .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]),
    .mem_rdata(m_rdata[0]), .mem_resp(m_resp[0]),
    .grant_idx(a_grant), .busy(a_busy)
  );

  mem_arbiter_n #(.NUM_REQ(4), .ADDR_W(32), .LINE_W(256), .RR_MODE(1)) u_b (
    .clk(clk), .rst(rst),
    .req_read(b_req_read), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_rdata(b_req_rdata), .req_resp(b_req_resp),
    .mem_read(m_read[1]), .mem_write(m_write[1]),
    .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]),
    .mem_rdata(m_rdata[1]), .mem_resp(m_resp[1]),
    .grant_idx(b_grant), .busy(b_busy)
  );

  function automatic logic [255:0] dflt(input logic [31:0] addr);
    return {8{addr}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model: responds after mem_wait strobe cycles and stores writes.
  // It also returns a stray resp when inject is set.
  initial begin : mem_model
    logic [255:0] mem [logic [32:0]];
    int cnt [2];
    logic [32:0] key;
    mem[{1'b0, 32'h40}] = {32{8'hAA}};
    m_resp = '0;
    for (int g = 0; g < 2; g++) begin
      m_rdata[g] = '0;
      cnt[g] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        m_resp[g]  = 1'b0;
        m_rdata[g] = '0;
        key = {1'(g), m_addr[g]};
        if (rst) begin
          cnt[g] = 0;
        end else if (inject[g]) begin
          m_resp[g]  = 1'b1;
          m_rdata[g] = {256{1'b1}};
        end else if (m_read[g] || m_write[g]) begin
          if (cnt[g] == mem_wait[g]) begin
            m_resp[g] = 1'b1;
            cnt[g] = 0;
            if (m_write[g]) mem[key] = m_wdata[g];
            else m_rdata[g] = mem.exists(key) ? mem[key] : dflt(m_addr[g]);
          end else begin
            cnt[g]++;
          end
        end else begin
          cnt[g] = 0;
        end
      end
    end
  end

  task automatic mon_check(input int g, input logic [3:0] resp, input logic [1:0] gidx,
                           input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wd, input logic [255:0] rline);
    exp_t e;
    string t;
    t = (g == 0) ? "a" : "b";
    if (g == 0 && q_a.size() == 0) begin
      check({t, "_unexpected_resp"}, resp, 0);
      return;
    end
    if (g == 1 && q_b.size() == 0) begin
      check({t, "_unexpected_resp"}, resp, 0);
      return;
    end
    if (g == 0) e = q_a.pop_front();
    else e = q_b.pop_front();
    check({t, "_resp_onehot"}, resp, 4'b1 << e.port);
    check({t, "_grant_idx"}, gidx, e.port);
    check({t, "_mem_write"}, wr, e.wr);
    check({t, "_mem_read"}, rd, !e.wr);
    check({t, "_mem_addr"}, addr, e.addr);
    if (e.wr) check({t, "_mem_wdata"}, wd, e.data);
    else check({t, "_rdata"}, rline, e.data);
  endtask

  // Monitor: compare every completion against the head of its queue.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && a_req_resp != '0)
        mon_check(0, {2'b00, a_req_resp}, {1'b0, a_grant}, m_read[0], m_write[0],
                  m_addr[0], m_wdata[0], a_req_rdata);
      if (!rst && b_req_resp != '0)
        mon_check(1, b_req_resp, b_grant, m_read[1], m_write[1],
                  m_addr[1], m_wdata[1], b_req_rdata);
    end
  end

  task automatic push(input int g, input int port, input bit wr, input logic [31:0] addr,
                      input logic [255:0] data);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.data = data;
    if (g == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic a_drive(input int p, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd);
    a_req_read[p] = rd; a_req_write[p] = wr;
    a_req_addr[p*32 +: 32] = addr; a_req_wdata[p*256 +: 256] = wd;
  endtask

  task automatic b_drive(input int p, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd);
    b_req_read[p] = rd; b_req_write[p] = wr;
    b_req_addr[p*32 +: 32] = addr; b_req_wdata[p*256 +: 256] = wd;
  endtask

  task automatic clear_counts();
    a_rd_cyc = 0; a_wr_cyc = 0; b_rd_cyc = 0; b_wr_cyc = 0; tick_no = 0; resp_at = 0;
  endtask

  // One clock: sample mid-cycle, then drop the requests of any port that got resp.
  task automatic tick();
    @(negedge clk);
    tick_no++;
    if (m_read[0]) a_rd_cyc++;
    if (m_write[0]) a_wr_cyc++;
    if (m_read[1]) b_rd_cyc++;
    if (m_write[1]) b_wr_cyc++;
    seen_a = a_req_resp;
    seen_b = b_req_resp;
    if ((seen_a != '0 || seen_b != '0) && resp_at == 0) resp_at = tick_no;
    @(posedge clk);
    #1;
    a_req_read &= ~seen_a; a_req_write &= ~seen_a;
    b_req_read &= ~seen_b; b_req_write &= ~seen_b;
  endtask

  function automatic bit pending();
    return ((a_req_read | a_req_write) != '0) || ((b_req_read | b_req_write) != '0);
  endfunction

  task automatic run_until_quiet(input string name, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    check({name, "_all_served"}, {a_req_read, a_req_write, b_req_read, b_req_write}, 0);
    check({name, "_queue_drained"}, q_a.size() + q_b.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int round [4];
    int n;
    rst = 1'b1;
    inject = '0;
    mem_wait[0] = 0; mem_wait[1] = 0;
    a_req_read = '0; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
    b_req_read = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_outputs", {m_read[0], m_write[0], a_req_resp, a_grant, a_busy}, 0);
    check("reset_a_addr", m_addr[0], 0);
    check("reset_a_wdata", m_wdata[0], 0);
    check("reset_b_outputs", {m_read[1], m_write[1], b_req_resp, b_grant, b_busy}, 0);
    check("reset_b_addr", m_addr[1], 0);
    check("reset_b_rdata", b_req_rdata, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin first, so the pointer starts from its reset value of 0.
    mem_wait[1] = 0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++)
        push(1, i, 1'b0, 32'h2000 + i * 32'h100 + j * 32'h10, dflt(32'h2000 + i * 32'h100 + j * 32'h10));
    for (int i = 0; i < 4; i++) begin
      b_drive(i, 1'b1, 1'b0, 32'h2000 + i * 32'h100, '0);
      round[i] = 0;
    end
    n = 0;
    while (pending() && n < 60) begin
      tick();
      n++;
      for (int i = 0; i < 4; i++)
        if (seen_b[i] && round[i] == 0) begin
          round[i] = 1;
          b_drive(i, 1'b1, 1'b0, 32'h2000 + i * 32'h100 + 32'h10, '0);
        end
    end
    check("rr_all_served", {b_req_read, b_req_write}, 0);
    check("rr_queue_drained", q_b.size(), 0);

    // Single port read with 3 wait cycles.
    mem_wait[0] = 3;
    clear_counts();
    a_drive(1, 1'b1, 1'b0, 32'h40, '0);
    push(0, 1, 1'b0, 32'h40, {32{8'hAA}});
    run_until_quiet("single", 40);
    tick();
    tick();
    check("single_read_cycles", a_rd_cyc, 4);
    check("single_write_cycles", a_wr_cyc, 0);
    check("single_latency", resp_at, 5);

    // Zero-wait memory gives the minimum latency of 2 cycles.
    mem_wait[0] = 0;
    clear_counts();
    a_drive(0, 1'b1, 1'b0, 32'h80, '0);
    push(0, 0, 1'b0, 32'h80, dflt(32'h80));
    run_until_quiet("min_lat", 20);
    check("min_latency", resp_at, 2);

    // Fixed priority: both ports in the same cycle, port 0 first.
    mem_wait[0] = 1;
    a_drive(0, 1'b1, 1'b0, 32'h100, '0);
    a_drive(1, 1'b1, 1'b0, 32'h200, '0);
    push(0, 0, 1'b0, 32'h100, dflt(32'h100));
    push(0, 1, 1'b0, 32'h200, dflt(32'h200));
    run_until_quiet("fixed_prio", 40);

    // Read+write together on port 0 is serviced as a single write.
    clear_counts();
    a_drive(0, 1'b1, 1'b1, 32'h300, {8{32'hDEAD_BEEF}});
    n_proto++;
    $display("protocol error: port 0 raised read and write together (%0d so far)", n_proto);
    push(0, 0, 1'b1, 32'h300, {8{32'hDEAD_BEEF}});
    run_until_quiet("rw_both", 30);
    check("rw_both_read_cycles", a_rd_cyc, 0);
    check("rw_both_write_cycles", a_wr_cyc, 2);
    a_drive(1, 1'b1, 1'b0, 32'h300, '0);
    push(0, 1, 1'b0, 32'h300, {8{32'hDEAD_BEEF}});
    run_until_quiet("rw_both_readback", 30);

    // Write path on port 2, then a read of the same line from port 0.
    mem_wait[1] = 2;
    clear_counts();
    b_drive(2, 1'b0, 1'b1, 32'h1000, {16{16'h1234}});
    push(1, 2, 1'b1, 32'h1000, {16{16'h1234}});
    run_until_quiet("write", 30);
    check("write_read_cycles", b_rd_cyc, 0);
    check("write_write_cycles", b_wr_cyc, 3);
    b_drive(0, 1'b1, 1'b0, 32'h1000, '0);
    push(1, 0, 1'b0, 32'h1000, {16{16'h1234}});
    run_until_quiet("write_readback", 30);

    // Reset during the second ISSUE cycle of a read, then a stray late mem_resp.
    mem_wait[1] = 5;
    b_drive(1, 1'b1, 1'b0, 32'h40, '0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_mid_busy_before", b_busy, 1);
    check("rst_mid_read_before", m_read[1], 1);
    rst = 1'b1;
    #1;
    check("rst_mid_strobes", {m_read[1], m_write[1], b_req_resp, b_grant, b_busy}, 0);
    check("rst_mid_addr", m_addr[1], 0);
    b_req_read = '0; b_req_write = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    inject[1] = 1'b1;
    @(posedge clk);
    #2;
    inject[1] = 1'b0;
    @(negedge clk);
    check("late_resp_present", m_resp[1], 1);
    check("late_resp_ignored", b_req_resp, 0);
    check("late_resp_rdata_zero", b_req_rdata, 0);
    check("late_resp_idle", {b_busy, m_read[1], m_write[1]}, 0);
    @(posedge clk);
    #1;
    mem_wait[1] = 0;
    b_drive(1, 1'b1, 1'b0, 32'h500, '0);
    b_drive(3, 1'b1, 1'b0, 32'h600, '0);
    push(1, 1, 1'b0, 32'h500, dflt(32'h500));
    push(1, 3, 1'b0, 32'h600, dflt(32'h600));
    run_until_quiet("after_reset", 30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
